popcount_vector_gen: RTL
========================

# popcount_vector_gen

Sequential stimulus generator for the 128-input approximate adder tree. It takes a requested population count K and produces 128-bit vectors containing exactly K ones, with the set bits placed by a programmable rotation. Vectors stream out as sixteen 8-bit beats, matching the tree's eight-input leaf groups. Each vector also carries the exact expected result (K and K[0]) so a checker can score the tree's output against ground truth.

## Interface
- No parameters; vector width fixed at 128, beat width fixed at 8, 16 beats per vector.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  generator idle, request accepted when req_valid & req_ready
- req_weight  in  8  target ones count K; values >128 clamp to 128
- req_rot  in  7  initial rotation R0
- req_step  in  7  rotation increment S between vectors of a burst
- req_len  in  8  burst length minus one (vectors = req_len+1, 1..256)
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  8  beat b = vec[8b+7:8b], b=0 first
- out_last  out  1  last beat (b=15) of a vector
- out_end  out  1  last beat of last vector of burst
- exp_count  out  8  clamped K of the current burst, held
- exp_lsb  out  1  exact popcount LSB = exp_count[0], held
- busy  out  1  burst in progress

## Operation
- Vector construction: therm[i] = 1 for i < K, else 0; vec[i] = therm[(i − R) mod 128], i.e. therm rotated left by R. Weight is always exactly K.
- Vector n of a burst uses R = (R0 + n·S) mod 128, accumulated in a 7-bit register (natural wrap).
- FSM states:
  - IDLE: req_ready=1, busy=0. On handshake latch clamped K, R0, S, req_len; set exp_count; go to BUILD.
  - BUILD: one cycle; register vec from K and current R; beat index ← 0; go to SEND.
  - SEND: out_valid=1; beat advances only when out_valid & out_ready. On accepted beat 15: if vectors remaining, R ← R+S and go to BUILD; else go to IDLE.
- out_data, out_last, and out_end are stable while out_valid=1 and out_ready=0.
- out_end=1 only together with out_last on the final vector.
- exp_count and exp_lsb update only on request acceptance. They hold after the burst ends until the next request.
- Requests presented while busy are not accepted (req_ready=0). They are neither queued nor dropped silently; the requester holds them.

## Timing
- Reset values: req_ready=1, out_valid=0, out_data=0x00, out_last=0, out_end=0, busy=0, exp_count=0, exp_lsb=0, R=0, beat index=0.
- Reset asserted mid-burst: the state machine returns to IDLE asynchronously and out_valid drops immediately. No further beats come from that burst.
- Request accepted at edge t: busy=1 and req_ready=0 from t; BUILD cycle t→t+1; first out_valid at t+1 (registered, visible after edge t+1).
- With out_ready held at 1: 16 beats per vector on consecutive cycles, plus one bubble cycle (BUILD) between vectors. A burst of N vectors takes 17·N cycles from acceptance to the final beat's edge.
- Final beat accepted at edge e: out_valid=0, busy=0, req_ready=1 after e. A new request can be accepted at edge e+1.
- K=0 yields all-zero beats; K=128 yields all 0xFF regardless of R.

## Test plan
- K=5, R0=0, len=0 → beat0 0x1F, beats1–15 0x00, out_last and out_end on beat 15, exp_lsb=1.
- K=5, R0=126 → set bits 126,127,0,1,2 → beat0 0x07, beat15 0xC0, others 0x00.
- K=8, R0=0, S=8, len=2 → vector0 beat0 0xFF, vector1 beat1 0xFF, vector2 beat2 0xFF, all other beats 0x00. out_last three times, out_end once. Total 51 cycles with out_ready=1.
- req_weight=200 → exp_count=128, every beat 0xFF. req_weight=0 → every beat 0x00, exp_lsb=0.
- Random out_ready throttling on a K=37 burst → data stable while stalled, no beat lost or duplicated, each vector sums to 37, req_ready=0 throughout.
- rst_n pulsed low at beat 7 of a burst → out_valid=0 and req_ready=1 immediately. A new request afterwards produces a correct, complete burst.

Source files
------------

// File: rtl/popcount_vector_gen_if.sv
// Request/beat bus of the popcount stimulus generator.
// The master drives requests and beat acceptance; the slave is the generator.
interface popcount_vector_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_weight;
  logic [6:0] req_rot;
  logic [6:0] req_step;
  logic [7:0] req_len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_end;
  logic [7:0] exp_count;
  logic       exp_lsb;
  logic       busy;

  modport master (
    output req_valid, req_weight, req_rot, req_step, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_end, exp_count, exp_lsb, busy
  );

  modport slave (
    input  req_valid, req_weight, req_rot, req_step, req_len, out_ready,
    output req_ready, out_valid, out_data, out_last, out_end, exp_count, exp_lsb, busy
  );
endinterface

// File: rtl/popcount_vector_gen.sv
// Streams 128-bit vectors holding exactly K ones (rotated thermometer code) as
// sixteen 8-bit beats, with the exact expected popcount held alongside.
module popcount_vector_gen (
  input  logic                  clk,
  input  logic                  rst_n,
  popcount_vector_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUILD, SEND} state_t;

  state_t       state_q, state_d;
  logic [7:0]   k_q, k_d;
  logic [6:0]   rot_q, rot_d;
  logic [6:0]   step_q, step_d;
  logic [7:0]   len_q, len_d;
  logic [3:0]   beat_q, beat_d;
  logic [7:0]   exp_q, exp_d;
  logic [127:0] vec_q, vec_d;

  logic [7:0]   k_clamp;
  logic [127:0] therm;
  logic [127:0] rot_vec;

  assign k_clamp = (bus.req_weight > 8'd128) ? 8'd128 : bus.req_weight;
  assign therm   = (k_q >= 8'd128) ? '1 : ((128'd1 << k_q) - 128'd1);
  // Rotate left by R; the right shift by 128 when R=0 yields zero, as needed.
  assign rot_vec = (therm << rot_q) | (therm >> (8'd128 - {1'b0, rot_q}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      rot_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      exp_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rot_q   <= rot_d;
      step_q  <= step_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rot_d   = rot_q;
    step_d  = step_q;
    len_d   = len_q;
    beat_d  = beat_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          k_d     = k_clamp;
          rot_d   = bus.req_rot;
          step_d  = bus.req_step;
          len_d   = bus.req_len;
          exp_d   = k_clamp;
          state_d = BUILD;
        end
      end
      BUILD: begin
        vec_d   = rot_vec;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (beat_q == 4'd15) begin
            if (len_q != 8'd0) begin
              len_d   = len_q - 8'd1;
              rot_d   = rot_q + step_q;
              state_d = BUILD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = vec_q[{beat_q, 3'b000} +: 8];
  assign bus.out_last  = (state_q == SEND) && (beat_q == 4'd15);
  assign bus.out_end   = (state_q == SEND) && (beat_q == 4'd15) && (len_q == 8'd0);
  assign bus.exp_count = exp_q;
  assign bus.exp_lsb   = exp_q[0];
endmodule
